cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
- Write-side controller for the dual-port frame buffer.
- Converts the OV7670 byte stream (vsync, href, 8-bit data in RGB444 mode) into buffer write transactions: address, 12-bit pixel and write strobe.
- Sequences capture frame by frame, in single-shot or continuous mode, with clipping to the buffer image size.
- Sits between the camera pins (already synchronised into clk) and the buffer write port; the VGA read side is untouched.

Parameters:
- AW, 15, buffer address width.
- DW, 12, pixel width; fixed RGB444, must equal 12.
- IMG_W, 160, pixels per stored line.
- IMG_H, 120, stored lines per frame; IMG_W*IMG_H <= 2**AW.

Ports:
- clk  in  1  capture clock (camera pixel clock domain); all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cap_en  in  1  level; continuous capture while high.
- cap_start  in  1  one-cycle pulse; capture exactly one frame.
- vsync  in  1  camera vertical sync; high = vertical blanking.
- href  in  1  camera line valid.
- px_data  in  8  camera byte.
- mem_addr  out  AW  buffer write address.
- mem_data  out  DW  buffer write data.
- mem_we  out  1  buffer write enable, one-cycle pulse per pixel.
- busy  out  1  high outside IDLE.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- short_frame  out  1  sticky per frame; valid with frame_done.
- frame_cnt  out  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset values: all outputs 0; state IDLE; x, y, row_base, phase = 0; vsync_d = 0, href_d = 0.
- Edge detection uses registered vsync_d and href_d:
  - frame start = vsync_d & ~vsync
  - frame end = ~vsync_d & vsync
  - line end = href_d & ~href
- IDLE:
  - cap_en=1 or cap_start=1 -> ARM.
  - Latch single = ~cap_en.
- ARM: wait for frame start; on it, clear x, y, row_base, phase and short flag -> CAPTURE.
  - Because vsync_d resets to 0, a falling edge needs vsync seen high first. A frame already in progress at reset is never captured.
- CAPTURE:
  - While href=1, each cycle samples one byte and toggles phase.
  - phase 0: hold px_data[3:0] as R.
  - phase 1: form pixel {R, px_data[7:4], px_data[3:0]}.
  - If x<IMG_W and y<IMG_H: next cycle mem_we=1, mem_addr=row_base+x, mem_data=pixel. Latency is 1 cycle from the sampling edge of byte 1 to the registered mem_we. Then x++.
  - Pixels beyond IMG_W or lines beyond IMG_H are dropped (no write) and x saturates. Writes never go outside 0..IMG_W*IMG_H-1.
  - Line end: if x<IMG_W, set short. Then x=0, phase=0 (a dangling odd byte is discarded). If y<IMG_H: y++ and row_base += IMG_W (no multiplier).
  - Frame end: if y<IMG_H, set short -> DONE. A frame end while href=1 is treated as line end in the same cycle.
- DONE, one cycle:
  - frame_done=1, short_frame=short, frame_cnt++.
  - Next state is ARM if cap_en=1 and single=0, else IDLE.
  - short_frame holds until the next frame start.
- Control changes:
  - cap_start while busy: ignored.
  - cap_en dropped mid-frame: the current frame completes, then IDLE.
  - cap_en raised during a single-shot: single clears, so capture continues.
- Reset mid-frame: immediate return to IDLE with outputs cleared. Partially written RAM contents are left as is.
- mem_we is never high in IDLE, ARM or DONE.

Decomposition:
- Package cam_ctrl_pkg holds:
  - state encoding IDLE=0, ARM=1, CAPTURE=2, DONE=3
  - RGB444 nibble positions
  - default IMG_W, IMG_H, AW constants
- One natural sub-module, cam_rgb444_pack: phase toggle plus byte-pair assembly. Its outputs are pixel and a pix_valid pulse; phase clears on line end.

Test Plan:
- Use IMG_W=4, IMG_H=3 except where stated.
- Nominal single shot:
  - Stimulus: cap_start pulse, vsync 1->0, 3 lines of href high for 8 cycles each with bytes 0x0A,0xBC repeated, then vsync 0->1.
  - Required: 12 writes, addr 0..11, data 0xABC each; frame_done one cycle; short_frame=0; frame_cnt=1; returns to IDLE.
- Clipping:
  - Stimulus: lines of 12 bytes (6 pixels), 5 lines.
  - Required: still exactly 12 writes, max addr 11; short_frame=0.
- Short frame:
  - Stimulus: 2 lines of 4 bytes each.
  - Required: writes to addrs 0,1,4,5; short_frame=1 with frame_done.
- Odd byte:
  - Stimulus: line of 7 bytes.
  - Required: 3 writes; the 7th byte is dropped; the next line starts at addr 4 with correct R nibble.
- Continuous mode and late arm:
  - Stimulus: cap_en=1 asserted mid-frame, then 2 full frames, then cap_en=0 mid-3rd frame.
  - Required: the partial frame is not written; frame_cnt reaches 3; IDLE after the 3rd frame_done.
- Reset mid-CAPTURE:
  - Stimulus: reset high for 1 cycle after 5 writes.
  - Required: the next cycle has mem_we=0, busy=0, frame_cnt=0; no further writes until a new cap_start and frame start.

Source files
------------

// File: rtl/cam_ctrl_pkg.sv
// Shared types and constants for the OV7670 capture (frame buffer write side) controller.
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  // RGB444 byte pair: byte 0 carries R in its low nibble, byte 1 carries {G, B}.
  localparam int NIB_W = 4;
  localparam int R_LSB = 0;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;
  localparam int PIX_W = 12;

  localparam int DEF_AW    = 15;
  localparam int DEF_IMG_W = 160;
  localparam int DEF_IMG_H = 120;

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera-side inputs, capture control and buffer write port of the capture controller.
interface cam_capture_ctrl_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          cap_en;
  logic          cap_start;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          busy;
  logic          frame_done;
  logic          short_frame;
  logic [7:0]    frame_cnt;

  modport master (
    input  cap_en, cap_start, vsync, href, px_data,
    output mem_addr, mem_data, mem_we, busy, frame_done, short_frame, frame_cnt
  );

  modport slave (
    output cap_en, cap_start, vsync, href, px_data,
    input  mem_addr, mem_data, mem_we, busy, frame_done, short_frame, frame_cnt
  );
endinterface

// File: rtl/cam_rgb444_pack.sv
// Pairs consecutive camera bytes into one RGB444 pixel; pix_valid fires on the second byte.
module cam_rgb444_pack
  import cam_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sample_i,
  input  logic             clr_i,
  input  logic [7:0]       px_data_i,
  output logic [PIX_W-1:0] pixel_o,
  output logic             pix_valid_o
);

  logic             phase_q, phase_d;
  logic [NIB_W-1:0] r_q, r_d;

  // Phase toggles per sampled byte; a clear drops any dangling first byte.
  always_comb begin
    phase_d = phase_q;
    r_d     = r_q;
    if (clr_i) begin
      phase_d = 1'b0;
    end else if (sample_i) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        r_d = px_data_i[R_LSB +: NIB_W];
      end else begin
        r_d = r_q;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase and held red nibble registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= 1'b0;
      r_q     <= {NIB_W{1'b0}};
    end else begin
      phase_q <= phase_d;
      r_q     <= r_d;
    end
  end

  assign pix_valid_o = sample_i & ~clr_i & phase_q;
  assign pixel_o     = {r_q, px_data_i[G_LSB +: NIB_W], px_data_i[B_LSB +: NIB_W]};

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame capture sequencer: turns the camera byte stream into clipped frame buffer writes.
module cam_capture_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = PIX_W,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic               clk,
  input  logic               reset,
  cam_capture_ctrl_if.master bus
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_MAX    = XW'(IMG_W);
  localparam logic [YW-1:0] Y_MAX    = YW'(IMG_H);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

  cap_state_e    state_q, state_d;
  logic          vsync_dly_q, href_dly_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic          short_q, short_d;
  logic          single_q, single_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          short_frame_q, short_frame_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic             frame_start_s, frame_end_s, line_end_s, line_close_s;
  logic             sample_s, clr_s, pix_valid_s;
  logic [PIX_W-1:0] pixel_s;

  assign frame_start_s = vsync_dly_q & ~bus.vsync;
  assign frame_end_s   = ~vsync_dly_q & bus.vsync;
  assign line_end_s    = href_dly_q & ~bus.href;
  // A frame end arriving with href still high closes the line instead of sampling a byte.
  assign line_close_s  = (state_q == CAPTURE) & (line_end_s | (frame_end_s & bus.href));
  assign sample_s      = (state_q == CAPTURE) & bus.href & ~frame_end_s;
  assign clr_s         = line_close_s | ((state_q == ARM) & frame_start_s);

  cam_rgb444_pack u_pack (
    .clk_i       (clk),
    .reset_i     (reset),
    .sample_i    (sample_s),
    .clr_i       (clr_s),
    .px_data_i   (bus.px_data),
    .pixel_o     (pixel_s),
    .pix_valid_o (pix_valid_s)
  );

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    row_base_d    = row_base_q;
    short_d       = short_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    frame_done_d  = 1'b0;
    short_frame_d = short_frame_q;
    frame_cnt_d   = frame_cnt_q;
    if ((state_q != IDLE) && bus.cap_en) begin
      single_d = 1'b0;
    end else begin
      single_d = single_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.cap_en || bus.cap_start) begin
          state_d  = ARM;
          single_d = ~bus.cap_en;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        if (frame_start_s) begin
          state_d       = CAPTURE;
          x_d           = {XW{1'b0}};
          y_d           = {YW{1'b0}};
          row_base_d    = {AW{1'b0}};
          short_d       = 1'b0;
          short_frame_d = 1'b0;
        end else begin
          state_d = ARM;
        end
      end
      CAPTURE: begin
        if (pix_valid_s && (x_q < X_MAX)) begin
          x_d = x_q + XW'(1);
          if (y_q < Y_MAX) begin
            we_d   = 1'b1;
            addr_d = row_base_q + AW'(x_q);
            data_d = DW'(pixel_s);
          end else begin
            we_d = 1'b0;
          end
        end else begin
          we_d = 1'b0;
        end
        if (line_close_s) begin
          short_d = short_q | (x_q < X_MAX);
          x_d     = {XW{1'b0}};
          if (y_q < Y_MAX) begin
            y_d        = y_q + YW'(1);
            row_base_d = row_base_q + ROW_STEP;
          end else begin
            y_d = y_q;
          end
        end else begin
          short_d = short_q;
        end
        // Uses the line count after any line closed in this same cycle.
        if (frame_end_s) begin
          state_d       = DONE;
          short_d       = short_d | (y_d < Y_MAX);
          frame_done_d  = 1'b1;
          short_frame_d = short_d;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end else begin
          state_d = CAPTURE;
        end
      end
      DONE: begin
        if (bus.cap_en && !single_d) begin
          state_d = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Sequential state; synchronous reset returns to IDLE with every output cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      vsync_dly_q   <= 1'b0;
      href_dly_q    <= 1'b0;
      x_q           <= {XW{1'b0}};
      y_q           <= {YW{1'b0}};
      row_base_q    <= {AW{1'b0}};
      short_q       <= 1'b0;
      single_q      <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= {AW{1'b0}};
      data_q        <= {DW{1'b0}};
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      vsync_dly_q   <= bus.vsync;
      href_dly_q    <= bus.href;
      x_q           <= x_d;
      y_q           <= y_d;
      row_base_q    <= row_base_d;
      short_q       <= short_d;
      single_q      <= single_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      short_frame_q <= short_frame_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.short_frame = short_frame_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl with a frame-level reference model (IMG_W=4, IMG_H=3).
module tb_cam_capture_ctrl;

  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic       sh;
    logic [7:0] cnt;
  } fr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cam_capture_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  cam_capture_ctrl #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         wr_seen = 0;
  wr_t        exp_wr[$];
  fr_t        exp_fr[$];
  int         lens_q[$];
  logic [7:0] mcnt = 8'd0;
  bit         frame_short;
  bit         prev_fd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every frame_done is popped from the scoreboard.
  initial begin
    wr_t e;
    fr_t f;
    forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus.mem_addr, bus.mem_data);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.mem_data), 32'(e.data));
          chk("wr_busy", 32'(bus.busy), 32'd1);
        end
      end
      if (bus.frame_done === 1'b1) begin
        chk("fd_one_cycle", 32'(prev_fd), 32'd0);
        if (exp_fr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_done: cnt %0d, expected none", bus.frame_cnt);
        end else begin
          f = exp_fr.pop_front();
          chk("short_frame", 32'(bus.short_frame), 32'(f.sh));
          chk("frame_cnt_at_done", 32'(bus.frame_cnt), 32'(f.cnt));
        end
      end
      prev_fd = bus.frame_done;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_data", 32'(bus.mem_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_short_frame", 32'(bus.short_frame), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    reset = 1'b0;
    mcnt  = 8'd0;
    repeat (2) tick();
  endtask

  // Model: pixel p of stored line li lands at li*IMG_W+p as {R of even byte, odd byte}.
  task automatic send_line(input int n, input bit cap, input int li, input bit rnd);
    logic [7:0] b0, v;
    b0 = 8'h00;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 8'($urandom) : (((i % 2) == 0) ? 8'h0A : 8'hBC);
      bus.href    = 1'b1;
      bus.px_data = v;
      if ((i % 2) == 0) begin
        b0 = v;
      end else if (cap && (li < IMG_H) && ((i / 2) < IMG_W)) begin
        exp_wr.push_back('{addr: AW'(li * IMG_W + i / 2), data: {b0[3:0], v}});
      end
      tick();
    end
    bus.href = 1'b0;
    if (cap && ((n / 2) < IMG_W)) frame_short = 1'b1;
  endtask

  task automatic run_frame(input bit cap, input bit rnd, input int en_on_at, input int en_off_at,
                           input int start_at);
    frame_short = (lens_q.size() < IMG_H);
    bus.vsync = 1'b0;
    tick();
    tick();
    foreach (lens_q[l]) begin
      if (l == en_on_at) bus.cap_en = 1'b1;
      if (l == en_off_at) bus.cap_en = 1'b0;
      if (l == start_at) begin
        bus.cap_start = 1'b1;
        tick();
        bus.cap_start = 1'b0;
      end
      send_line(lens_q[l], cap, l, rnd);
      repeat ($urandom_range(2, 4)) tick();
    end
    bus.vsync = 1'b1;
    if (cap) begin
      mcnt++;
      exp_fr.push_back('{sh: frame_short, cnt: mcnt});
    end
    repeat (4) tick();
  endtask

  task automatic set_uniform(input int nl, input int len);
    lens_q.delete();
    for (int i = 0; i < nl; i++) lens_q.push_back(len);
  endtask

  task automatic single(input bit rnd, input int start_at);
    bus.cap_start = 1'b1;
    tick();
    bus.cap_start = 1'b0;
    run_frame(1'b1, rnd, -1, -1, start_at);
    chk("single_back_idle", 32'(bus.busy), 32'd0);
    chk("single_frame_cnt", 32'(bus.frame_cnt), 32'(mcnt));
  endtask

  initial begin
    logic [7:0] b0, b1;
    reset         = 1'b1;
    bus.cap_en    = 1'b0;
    bus.cap_start = 1'b0;
    bus.vsync     = 1'b1;
    bus.href      = 1'b0;
    bus.px_data   = 8'h00;
    tick();
    do_reset();

    // Nominal single shot, clipping, short frame (with ignored cap_start), odd byte.
    set_uniform(3, 8);
    single(1'b0, -1);
    chk("nominal_cnt", 32'(bus.frame_cnt), 32'd1);
    set_uniform(5, 12);
    single(1'b1, -1);
    set_uniform(2, 4);
    single(1'b1, 1);
    lens_q.delete();
    lens_q.push_back(7);
    lens_q.push_back(8);
    lens_q.push_back(8);
    single(1'b1, -1);

    // Randomised single-shot frames.
    for (int f = 0; f < 8; f++) begin
      int nl;
      nl = $urandom_range(1, 5);
      lens_q.delete();
      for (int l = 0; l < nl; l++) lens_q.push_back($urandom_range(1, 12));
      single(1'b1, ($urandom_range(0, 1) == 1) ? 0 : -1);
    end

    // Continuous mode armed mid-frame; stop during the third captured frame.
    do_reset();
    set_uniform(3, 8);
    run_frame(1'b0, 1'b1, 1, -1, -1);
    run_frame(1'b1, 1'b1, -1, -1, -1);
    run_frame(1'b1, 1'b1, -1, -1, -1);
    run_frame(1'b1, 1'b1, -1, 1, -1);
    chk("cont_idle", 32'(bus.busy), 32'd0);
    chk("cont_cnt", 32'(bus.frame_cnt), 32'd3);

    // Reset in the middle of CAPTURE after five writes.
    do_reset();
    bus.cap_start = 1'b1;
    tick();
    bus.cap_start = 1'b0;
    bus.vsync = 1'b0;
    tick();
    tick();
    wr_seen = 0;
    send_line(8, 1'b1, 0, 1'b1);
    repeat (2) tick();
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    bus.href    = 1'b1;
    bus.px_data = b0;
    tick();
    bus.px_data = b1;
    exp_wr.push_back('{addr: AW'(IMG_W), data: {b0[3:0], b1}});
    tick();
    for (int k = 0; k < 20 && wr_seen < 5; k++) tick();
    chk("writes_before_reset", 32'(wr_seen), 32'd5);
    bus.px_data = 8'($urandom);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mcnt  = 8'd0;
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.px_data = 8'($urandom);
      tick();
    end
    bus.href = 1'b0;
    repeat (2) tick();
    bus.vsync = 1'b1;
    repeat (4) tick();
    set_uniform(3, 8);
    run_frame(1'b0, 1'b1, -1, -1, -1);
    chk("no_write_after_reset", 32'(wr_seen), 32'd5);
    single(1'b0, -1);

    repeat (10) tick();
    chk("exp_writes_drained", 32'(exp_wr.size()), 32'd0);
    chk("exp_frames_drained", 32'(exp_fr.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
